// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage indices, controller state type and the
// exception codes that cp0 and mem also use.
package pipe_pkg;

  localparam int unsigned NUM_STG = 5;
  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_WB  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } pipe_state_t;

  localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXC_INT       = 32'h0000_0001;
  localparam logic [31:0] EXC_TLBREFILL = 32'h0000_0002;
  localparam logic [31:0] EXC_ERET      = 32'h0000_000E;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the pipeline stages/cp0 and pipe_ctrl.
// Perf counter outputs exist only when PIPE_PERF_EN is defined.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        if_busy;
  logic [31:0] wb_except_type;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_ebase;
  logic        cp0_exl;
  logic [4:0]  stage_en;
  logic [4:0]  stage_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] perf_stall_cyc;
  logic [CNT_W-1:0] perf_flush_cnt;
`endif

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, if_busy,
    output wb_except_type, cp0_epc, cp0_ebase, cp0_exl,
`ifdef PIPE_PERF_EN
    input  perf_stall_cyc, perf_flush_cnt,
`endif
    input  stage_en, stage_flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, if_busy,
    input  wb_except_type, cp0_epc, cp0_ebase, cp0_exl,
`ifdef PIPE_PERF_EN
    output perf_stall_cyc, perf_flush_cnt,
`endif
    output stage_en, stage_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipe_stall_enc.sv
// Priority encoder: the deepest stall requester holds every stage before it
// and injects a bubble into its own pipeline register.
module pipe_stall_enc
  import pipe_pkg::*;
(
  input  logic [3:0] i_req,   // [0]=IF [1]=ID [2]=EX [3]=MEM
  output logic [4:0] o_en,
  output logic [4:0] o_flush
);

  int unsigned w_k;

  always_comb begin
    w_k = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_req[i]) w_k = i + 1;
    end
    o_en    = '1;
    o_flush = '0;
    for (int unsigned j = 0; j < NUM_STG; j++) begin
      if (j < w_k) o_en[j] = 1'b0;
      if (w_k != 0 && j == w_k) o_flush[j] = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline.
// Optional perf counters: define PIPE_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] GEN_OFF    = 32'h180,
  parameter logic [31:0] REFILL_OFF = 32'h000,
  parameter int unsigned CNT_W      = 32
)(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  pipe_state_t r_state, w_next;
  logic [31:0] r_tgt, w_tgt;
  logic [4:0]  w_enc_en, w_enc_flush;
  logic        w_exc;
  logic        w_accept;

  pipe_stall_enc u_stall_enc (
    .i_req   ({bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if}),
    .o_en    (w_enc_en),
    .o_flush (w_enc_flush)
  );

  assign w_exc    = |bus.wb_except_type;
  assign w_accept = (r_state == ST_RUN) && w_exc;

  always_comb begin
    if (bus.wb_except_type == EXC_ERET)
      w_tgt = bus.cp0_epc;
    else if (bus.wb_except_type == EXC_TLBREFILL && !bus.cp0_exl)
      w_tgt = bus.cp0_ebase + REFILL_OFF;
    else
      w_tgt = bus.cp0_ebase + GEN_OFF;
  end

  always_comb begin
    w_next             = r_state;
    bus.stage_en       = 5'b11111;
    bus.stage_flush    = 5'b00000;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = r_tgt;
    if (rst) begin
      w_next          = ST_RUN;
      bus.stage_en    = 5'b00000;
      bus.stage_flush = 5'b11110;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc) begin
            bus.stage_en    = 5'b11110;
            bus.stage_flush = 5'b11110;
            w_next          = bus.if_busy ? ST_DRAIN : ST_REDIR;
          end else begin
            bus.stage_en    = w_enc_en;
            bus.stage_flush = w_enc_flush;
          end
        end
        ST_DRAIN: begin
          bus.stage_en    = 5'b11110;
          bus.stage_flush = 5'b11110;
          if (!bus.if_busy) w_next = ST_REDIR;
        end
        ST_REDIR: begin
          bus.stage_en       = 5'b11111;
          bus.stage_flush    = 5'b11110;
          bus.redirect_valid = 1'b1;
          w_next             = ST_RUN;
        end
        default: w_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_tgt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_tgt <= w_tgt;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cyc, r_flush_cnt;
  logic             w_any_stall;

  assign w_any_stall = bus.stallreq_if | bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == ST_RUN && w_any_stall) r_stall_cyc <= r_stall_cyc + 1'b1;
      if (w_accept) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cyc = r_stall_cyc;
  assign bus.perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; expected values are hand-computed.
module tb_pipe_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(
    .GEN_OFF    (32'h180),
    .REFILL_OFF (32'h000),
    .CNT_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then leave a settling gap before inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stall(input logic [3:0] req);
    {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id, bus.stallreq_if} = req;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] en, input logic [4:0] fl,
                         input logic rv);
    check({tag, ".en"}, {27'd0, bus.stage_en}, {27'd0, en});
    check({tag, ".flush"}, {27'd0, bus.stage_flush}, {27'd0, fl});
    check({tag, ".rv"}, {31'd0, bus.redirect_valid}, {31'd0, rv});
  endtask

  // Raise an exception in RUN for one cycle, then clear it.
  task automatic raise(input logic [31:0] code, input logic busy);
    bus.wb_except_type = code;
    bus.if_busy = busy;
    #1;
    chk_out("exc_T", 5'b11110, 5'b11110, 1'b0);
    tick();
    bus.wb_except_type = EXC_NONE;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.stallreq_if = 1'b0; bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0; bus.stallreq_mem = 1'b0;
    bus.if_busy = 1'b0;
    bus.wb_except_type = EXC_NONE;
    bus.cp0_epc = 32'h0;
    bus.cp0_ebase = 32'h8000_0000;
    bus.cp0_exl = 1'b0;
    tick(); tick();
    chk_out("reset", 5'b00000, 5'b11110, 1'b0);

    rst = 1'b0;
    #1;
    chk_out("idle", 5'b11111, 5'b00000, 1'b0);

    // Stall encoding table
    set_stall(4'b0100); chk_out("st_ex",     5'b11000, 5'b01000, 1'b0);
    set_stall(4'b1001); chk_out("st_if_mem", 5'b10000, 5'b10000, 1'b0);
    set_stall(4'b0010); chk_out("st_id",     5'b11100, 5'b00100, 1'b0);
    set_stall(4'b0001); chk_out("st_if",     5'b11110, 5'b00010, 1'b0);
    set_stall(4'b0110); chk_out("st_id_ex",  5'b11000, 5'b01000, 1'b0);
    set_stall(4'b1000); chk_out("st_mem",    5'b10000, 5'b10000, 1'b0);

    // Exception overrides stalls; no drain
    set_stall(4'b0100);
    tick();
    raise(EXC_INT, 1'b0);
    set_stall(4'b0000);
    chk_out("int_redir", 5'b11111, 5'b11110, 1'b1);
    check("int_pc", bus.redirect_pc, 32'h8000_0180);
    tick();
    chk_out("int_back", 5'b11111, 5'b00000, 1'b0);

    // ERET with three drain cycles; stalls ignored while draining
    bus.cp0_epc = 32'hBFC0_0100;
    raise(EXC_ERET, 1'b1);
    bus.stallreq_mem = 1'b1;
    #1;
    chk_out("drain1", 5'b11110, 5'b11110, 1'b0);
    tick();
    chk_out("drain2", 5'b11110, 5'b11110, 1'b0);
    tick();
    bus.if_busy = 1'b0;
    bus.stallreq_mem = 1'b0;
    #1;
    chk_out("drain3", 5'b11110, 5'b11110, 1'b0);
    tick();
    chk_out("eret_redir", 5'b11111, 5'b11110, 1'b1);
    check("eret_pc", bus.redirect_pc, 32'hBFC0_0100);
    tick();
    chk_out("eret_back", 5'b11111, 5'b00000, 1'b0);

    // TLB refill vector selection by EXL
    bus.cp0_exl = 1'b0;
    raise(EXC_TLBREFILL, 1'b0);
    check("refill_exl0_rv", {31'd0, bus.redirect_valid}, 32'd1);
    check("refill_exl0_pc", bus.redirect_pc, 32'h8000_0000);
    tick();
    bus.cp0_exl = 1'b1;
    raise(EXC_TLBREFILL, 1'b0);
    check("refill_exl1_pc", bus.redirect_pc, 32'h8000_0180);
    tick();
    bus.cp0_exl = 1'b0;

    // General vector wraps at 32 bits
    bus.cp0_ebase = 32'hFFFF_FF00;
    raise(EXC_INT, 1'b0);
    check("wrap_pc", bus.redirect_pc, 32'h0000_0080);
    tick();
    bus.cp0_ebase = 32'h8000_0000;

`ifdef PIPE_PERF_EN
    check("perf_flush_pre", bus.perf_flush_cnt, 32'd5);
`endif

    // Reset mid-drain aborts the redirect
    raise(EXC_INT, 1'b1);
    chk_out("rdrain", 5'b11110, 5'b11110, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("rdrain_rst", 5'b00000, 5'b11110, 1'b0);
    tick();
    rst = 1'b0;
    bus.if_busy = 1'b0;
    #1;
    chk_out("rdrain_run", 5'b11111, 5'b00000, 1'b0);
    tick();
    chk_out("rdrain_run2", 5'b11111, 5'b00000, 1'b0);
`ifdef PIPE_PERF_EN
    check("perf_stall_rst", bus.perf_stall_cyc, 32'd0);
    check("perf_flush_rst", bus.perf_flush_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
